spm_access_arbiter: RTL
=======================

Name: spm_access_arbiter

Overview:
- Shares one scratchpad memory between two requesters. Port A is the core data path; port B is the boot loader / DMA path.
- The memory has one synchronous-read port and one byte-lane write port.
- After reset the block stays in BOOT, where only port B is served. Once B signals `b_done`, the block moves to RUN and round-robins between the two ports.
- It issues at most one memory operation per cycle, fully pipelined, with 1-cycle response latency.

Parameters:
- ADDR_WIDTH, 32, requester byte-address width.
- MEM_ADDR_WIDTH, 32, width of the memory word-address ports.
- DATA_WIDTH, 32, word width; the number of byte lanes is DATA_WIDTH/8, which is 4.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- a_valid  in  1  port A request valid.
- a_ready  out  1  port A request accepted this cycle.
- a_write  in  1  1 = store, 0 = load.
- a_addr  in  ADDR_WIDTH  byte address; bits [1:0] are ignored.
- a_wdata  in  DATA_WIDTH  store data.
- a_mask  in  4  byte-lane store enables.
- a_rsp_valid  out  1  response for port A.
- a_rsp_data  out  DATA_WIDTH  load data; 0 for stores.
- b_valid, b_ready, b_write, b_addr, b_wdata, b_mask, b_rsp_valid, b_rsp_data: same as the port A signals, for port B.
- b_done  in  1  single-cycle pulse: boot load finished.
- boot_active  out  1  high while in BOOT.
- mem_rdAddress  out  MEM_ADDR_WIDTH  memory read word address.
- mem_rdData  in  DATA_WIDTH  memory read data, valid 1 cycle after the address.
- mem_wrAddress  out  MEM_ADDR_WIDTH  memory write word address.
- mem_wrData  out  DATA_WIDTH  memory write data.
- mem_wrEnable  out  4  per-lane write enables.

Behaviour:
- **Clock and reset:** one clock, `clock`. Reset `reset` is synchronous and active-high.
- **Reset values:**
  - State = BOOT; round-robin pointer = A.
  - `a_ready`, `b_ready`, `a_rsp_valid`, `b_rsp_valid` = 0.
  - Response data = 0.
  - `mem_*` outputs = 0.
  - `boot_active` = 1.
- **FSM:**
  - BOOT -> RUN on `b_done` = 1. There is no path back except reset.
  - In BOOT, port A is never granted (`a_ready` = 0). Port B is granted whenever `b_valid` = 1.
  - A `b_done` that arrives in the same cycle as a B request still grants that request. RUN arbitration starts the next cycle.
- **RUN arbitration:**
  - If exactly one port is valid, it is granted.
  - If both are valid, the port not granted most recently wins.
  - The pointer updates only on a grant.
  - No grant is made when no port is valid.
- **Ready rule:** `x_ready` is combinational from the grant and equals `x_valid & grant_x`. A request transfers on `valid & ready`. Requesters hold stable while `valid & !ready`.
- **Address mapping:** word address = `addr[ADDR_WIDTH-1:2]`, zero-extended or truncated to MEM_ADDR_WIDTH.
- **Granted load:**
  - `mem_rdAddress` = word address in the grant cycle.
  - In the next cycle, `x_rsp_valid` = 1 and `x_rsp_data` = `mem_rdData`.
- **Granted store:**
  - `mem_wrAddress`, `mem_wrData` and `mem_wrEnable` = `x_mask`, all in the grant cycle.
  - The next cycle gives `x_rsp_valid` = 1 with `x_rsp_data` = 0 (write acknowledge).
  - A mask of 0 still produces the acknowledge.
- **Idle cycles:** `mem_wrEnable` = 0; `mem_rdAddress` and `mem_wrAddress` = 0.
- **Throughput:** back-to-back grants are allowed every cycle. Responses are registered, at most one per cycle, and never to both ports in the same cycle.
- **Ordering:** a load issued the cycle after a store to the same word returns the stored data. This relies on the memory's write-then-read ordering; the block adds no forwarding.
- **Reset mid-operation:** an in-flight response is dropped; `rsp_valid` = 0 in the cycle after reset. The FSM returns to BOOT.

Test Plan:
- **BOOT gating:** after reset, A loads 0x10 and B stores 0xDEADBEEF to 0x10 with mask 0xF, both valid together. Required: only `b_ready` = 1; `mem_wrAddress` = 4; `mem_wrEnable` = 0xF; `b_rsp_valid` the next cycle with data 0; `a_ready` = 0 throughout BOOT.
- **BOOT exit:** pulse `b_done`. Required: `boot_active` = 0 the next cycle. Then A loads 0x10: `mem_rdAddress` = 4, and the next cycle gives `a_rsp_valid` = 1, `a_rsp_data` = 0xDEADBEEF.
- **Round-robin fairness:** in RUN, A and B both keep loads valid for 4 cycles. Required: grants alternate A, B, A, B (A first after reset), and each response arrives 1 cycle after its grant.
- **Byte-lane store:** A stores 0x000000AA to 0x10 with mask 0x1. Required: `mem_wrEnable` = 0x1. A following load of 0x10 returns 0xDEADBEAA.
- **Reset mid-operation:** A load is granted, and reset is asserted in the next cycle. Required: `a_rsp_valid` = 0 in the cycle after reset, and the block is back in BOOT (`boot_active` = 1).

Source files
------------

// File: rtl/spm_access_arbiter_if.sv
// Requester, boot-control and scratchpad signals of the SPM access arbiter.
// slave = arbiter side, master = requesters plus memory.
interface spm_access_arbiter_if #(
  parameter int ADDR_WIDTH     = 32,
  parameter int MEM_ADDR_WIDTH = 32,
  parameter int DATA_WIDTH     = 32
);
  localparam int NB = DATA_WIDTH / 8;

  logic                      a_valid;
  logic                      a_ready;
  logic                      a_write;
  logic [ADDR_WIDTH-1:0]     a_addr;
  logic [DATA_WIDTH-1:0]     a_wdata;
  logic [NB-1:0]             a_mask;
  logic                      a_rsp_valid;
  logic [DATA_WIDTH-1:0]     a_rsp_data;

  logic                      b_valid;
  logic                      b_ready;
  logic                      b_write;
  logic [ADDR_WIDTH-1:0]     b_addr;
  logic [DATA_WIDTH-1:0]     b_wdata;
  logic [NB-1:0]             b_mask;
  logic                      b_rsp_valid;
  logic [DATA_WIDTH-1:0]     b_rsp_data;

  logic                      b_done;
  logic                      boot_active;

  logic [MEM_ADDR_WIDTH-1:0] mem_rdAddress;
  logic [DATA_WIDTH-1:0]     mem_rdData;
  logic [MEM_ADDR_WIDTH-1:0] mem_wrAddress;
  logic [DATA_WIDTH-1:0]     mem_wrData;
  logic [NB-1:0]             mem_wrEnable;

  modport slave (
    input  a_valid, a_write, a_addr, a_wdata, a_mask,
    output a_ready, a_rsp_valid, a_rsp_data,
    input  b_valid, b_write, b_addr, b_wdata, b_mask,
    output b_ready, b_rsp_valid, b_rsp_data,
    input  b_done,
    output boot_active,
    output mem_rdAddress, mem_wrAddress, mem_wrData, mem_wrEnable,
    input  mem_rdData
  );

  modport master (
    output a_valid, a_write, a_addr, a_wdata, a_mask,
    input  a_ready, a_rsp_valid, a_rsp_data,
    output b_valid, b_write, b_addr, b_wdata, b_mask,
    input  b_ready, b_rsp_valid, b_rsp_data,
    output b_done,
    input  boot_active,
    input  mem_rdAddress, mem_wrAddress, mem_wrData, mem_wrEnable,
    output mem_rdData
  );
endinterface

// File: rtl/spm_access_arbiter.sv
// Two-port scratchpad arbiter: B-only during BOOT, round-robin in RUN; one op per cycle,
// response 1 cycle after grant; ready = valid & grant, losers hold their request.
module spm_access_arbiter #(
  parameter int ADDR_WIDTH     = 32,
  parameter int MEM_ADDR_WIDTH = 32,
  parameter int DATA_WIDTH     = 32
) (
  input  logic                 clock,
  input  logic                 reset,
  spm_access_arbiter_if.slave  bus
);
  localparam int NB = DATA_WIDTH / 8;

  typedef enum logic {ST_BOOT = 1'b0, ST_RUN = 1'b1} state_t;

  state_t                    r_state;
  logic                      r_boot_active;
  logic                      r_pri_b;
  logic                      r_a_rsp_vld;
  logic                      r_b_rsp_vld;
  logic                      r_rsp_rd;

  logic                      w_gnt_a;
  logic                      w_gnt_b;
  logic                      w_sel_write;
  logic [MEM_ADDR_WIDTH-1:0] w_a_word;
  logic [MEM_ADDR_WIDTH-1:0] w_b_word;
  logic [MEM_ADDR_WIDTH-1:0] w_sel_word;
  logic [DATA_WIDTH-1:0]     w_sel_wdata;
  logic [NB-1:0]             w_sel_mask;
  logic                      w_a_rsp_vld;
  logic                      w_b_rsp_vld;

  // Byte address to word address; the cast zero-extends or truncates as needed.
  assign w_a_word = MEM_ADDR_WIDTH'(bus.a_addr >> 2);
  assign w_b_word = MEM_ADDR_WIDTH'(bus.b_addr >> 2);

  always_comb begin
    w_gnt_a = 1'b0;
    w_gnt_b = 1'b0;
    if (!reset) begin
      if (r_state == ST_BOOT) begin
        w_gnt_b = bus.b_valid;
      end else if (bus.a_valid && bus.b_valid) begin
        w_gnt_a = !r_pri_b;
        w_gnt_b = r_pri_b;
      end else begin
        w_gnt_a = bus.a_valid;
        w_gnt_b = bus.b_valid;
      end
    end
  end

  assign w_sel_write = w_gnt_a ? bus.a_write : bus.b_write;
  assign w_sel_word  = w_gnt_a ? w_a_word    : w_b_word;
  assign w_sel_wdata = w_gnt_a ? bus.a_wdata : bus.b_wdata;
  assign w_sel_mask  = w_gnt_a ? bus.a_mask  : bus.b_mask;

  always_comb begin
    bus.mem_rdAddress = '0;
    bus.mem_wrAddress = '0;
    bus.mem_wrData    = '0;
    bus.mem_wrEnable  = '0;
    if (w_gnt_a || w_gnt_b) begin
      if (w_sel_write) begin
        bus.mem_wrAddress = w_sel_word;
        bus.mem_wrData    = w_sel_wdata;
        bus.mem_wrEnable  = w_sel_mask;
      end else begin
        bus.mem_rdAddress = w_sel_word;
      end
    end
  end

  assign bus.a_ready = w_gnt_a;
  assign bus.b_ready = w_gnt_b;

  // Response valids are masked during reset so an in-flight response never escapes.
  assign w_a_rsp_vld     = r_a_rsp_vld && !reset;
  assign w_b_rsp_vld     = r_b_rsp_vld && !reset;
  assign bus.a_rsp_valid = w_a_rsp_vld;
  assign bus.b_rsp_valid = w_b_rsp_vld;
  assign bus.a_rsp_data  = (w_a_rsp_vld && r_rsp_rd) ? bus.mem_rdData : '0;
  assign bus.b_rsp_data  = (w_b_rsp_vld && r_rsp_rd) ? bus.mem_rdData : '0;
  assign bus.boot_active = r_boot_active;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state       <= ST_BOOT;
      r_boot_active <= 1'b1;
      r_pri_b       <= 1'b0;
      r_a_rsp_vld   <= 1'b0;
      r_b_rsp_vld   <= 1'b0;
      r_rsp_rd      <= 1'b0;
    end else begin
      if (r_state == ST_BOOT && bus.b_done) begin
        r_state       <= ST_RUN;
        r_boot_active <= 1'b0;
      end
      // Priority goes to whichever port was not granted last.
      if (w_gnt_a) begin
        r_pri_b <= 1'b1;
      end else if (w_gnt_b) begin
        r_pri_b <= 1'b0;
      end
      r_a_rsp_vld <= w_gnt_a;
      r_b_rsp_vld <= w_gnt_b;
      r_rsp_rd    <= (w_gnt_a || w_gnt_b) && !w_sel_write;
    end
  end
endmodule
